// File: rtl/spart_bus_if.sv
// spart_bus_if: SPART control/status strobes shared between the bus driver and the SPART.
// The 8-bit bidirectional databus travels as a separate inout port.
interface spart_bus_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_bus_driver.sv
// spart_bus_driver: programs the SPART baud divisor from br_cfg, then echoes received bytes back out.
// Define DRIVER_TXQ_EN to replace the single hold register with a TXQ_DEPTH-entry echo FIFO.
module spart_bus_driver #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD0     = 4800,
    parameter int BAUD1     = 9600,
    parameter int BAUD2     = 19200,
    parameter int BAUD3     = 38400,
    parameter int TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    spart_bus_if.master bus,
    inout  wire  [7:0]  databus,
    output logic        cfg_done,
    output logic [15:0] echo_cnt
);
    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WAIT_TX, WR} state_e;
    localparam logic [15:0] DIV0 = 16'(CLK_HZ / (16 * BAUD0) - 1);
    localparam logic [15:0] DIV1 = 16'(CLK_HZ / (16 * BAUD1) - 1);
    localparam logic [15:0] DIV2 = 16'(CLK_HZ / (16 * BAUD2) - 1);
    localparam logic [15:0] DIV3 = 16'(CLK_HZ / (16 * BAUD3) - 1);
    if (TXQ_DEPTH < 2 || (TXQ_DEPTH & (TXQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TXQ_DEPTH must be a power of 2 and at least 2");
    end
    state_e      state_q, state_d;
    logic [1:0]  cfg_q;
    logic        cfg_done_q;
    logic [15:0] echo_cnt_q;
    logic [15:0] div;
    logic        cs, rw;
    logic [1:0]  addr;
    logic [7:0]  dout, tx_data;
    logic        reconf, go_rd, go_wr;
    assign reconf = br_cfg != cfg_q;
    assign div = cfg_q[1] ? (cfg_q[0] ? DIV3 : DIV2) : (cfg_q[0] ? DIV1 : DIV0);
`ifdef DRIVER_TXQ_EN
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam state_e RD_NEXT = IDLE;
    logic [7:0]  mem_q [TXQ_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic        full, empty;
    assign empty   = wp_q == rp_q;
    assign full    = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    assign go_rd   = bus.rda && !full;
    assign go_wr   = bus.tbr && !empty;
    assign tx_data = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (state_q == RD) mem_q[wp_q[AW-1:0]] <= databus;
    end
    // Reset and reconfiguration both drop any queued echo bytes.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && reconf)) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (state_q == RD) wp_q <= wp_q + (AW + 1)'(1);
            if (state_q == WR) rp_q <= rp_q + (AW + 1)'(1);
        end
    end
`else
    localparam state_e RD_NEXT = WAIT_TX;
    logic [7:0] hold_q;
    assign go_rd   = bus.rda;
    assign go_wr   = 1'b0;
    assign tx_data = hold_q;
    always_ff @(posedge clk) begin
        hold_q <= rst ? 8'h00 : (state_q == RD) ? databus : hold_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CFG_LO;
            cfg_q      <= br_cfg;
            cfg_done_q <= 1'b0;
            echo_cnt_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == CFG_HI) cfg_done_q <= 1'b1;
            if (state_q == IDLE && reconf) begin
                cfg_q      <= br_cfg;
                cfg_done_q <= 1'b0;
            end
            if (state_q == WR) echo_cnt_q <= echo_cnt_q + 16'd1;
        end
    end
    always_comb begin
        state_d = state_q;
        cs      = 1'b0;
        rw      = 1'b1;
        addr    = 2'b00;
        dout    = 8'h00;
        case (state_q)
            CFG_LO:  begin cs = 1'b1; rw = 1'b0; addr = 2'b10; dout = div[7:0]; state_d = CFG_HI; end
            CFG_HI:  begin cs = 1'b1; rw = 1'b0; addr = 2'b11; dout = div[15:8]; state_d = IDLE; end
            IDLE:    state_d = reconf ? CFG_LO : go_rd ? RD : go_wr ? WR : IDLE;
            RD:      begin cs = 1'b1; state_d = RD_NEXT; end
            WAIT_TX: state_d = bus.tbr ? WR : WAIT_TX;
            WR:      begin cs = 1'b1; rw = 1'b0; dout = tx_data; state_d = IDLE; end
            default: state_d = CFG_LO;
        endcase
    end
    // Masking with rst keeps the bus quiet during reset even though state_q already sits in CFG_LO.
    assign bus.iocs   = cs && !rst;
    assign bus.iorw   = rw || rst;
    assign bus.ioaddr = rst ? 2'b00 : addr;
    assign databus    = (cs && !rw && !rst) ? dout : 8'hzz;
    assign cfg_done   = cfg_done_q;
    assign echo_cnt   = echo_cnt_q;
endmodule

// File: tb/tb_spart_bus_driver.sv
// tb_spart_bus_driver: directed checks of configuration writes, echo timing, reprogramming and reset abort.
module tb_spart_bus_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  br_cfg;
    logic [7:0]  rx;
    logic        cfg_done;
    logic [15:0] echo_cnt;
    wire  [7:0]  databus;
    int          checks = 0;
    int          failures = 0;
    spart_bus_if bus ();
    spart_bus_driver dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .bus(bus),
        .databus(databus), .cfg_done(cfg_done), .echo_cnt(echo_cnt)
    );
    always #5 clk = ~clk;
    assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) ? rx : 8'hzz;
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic chk_wr(input string tag, input logic [1:0] addr, input logic [7:0] data);
        chk({tag, "_cs"}, 16'(bus.iocs), 16'd1);
        chk({tag, "_rw"}, 16'(bus.iorw), 16'd0);
        chk({tag, "_addr"}, 16'(bus.ioaddr), 16'(addr));
        chk({tag, "_data"}, 16'(databus), 16'(data));
    endtask
    task automatic chk_rd(input string tag, input logic [7:0] data);
        chk({tag, "_cs"}, 16'(bus.iocs), 16'd1);
        chk({tag, "_rw"}, 16'(bus.iorw), 16'd1);
        chk({tag, "_addr"}, 16'(bus.ioaddr), 16'd0);
        chk({tag, "_data"}, 16'(databus), 16'(data));
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_cs"}, 16'(bus.iocs), 16'd0);
        chk({tag, "_rw"}, 16'(bus.iorw), 16'd1);
    endtask
    initial begin
        rst = 1'b1; br_cfg = 2'b01; rx = 8'h00; bus.rda = 1'b0; bus.tbr = 1'b0;
        step();
        step();
        chk_quiet("rst");
        chk("rst_addr", 16'(bus.ioaddr), 16'd0);
        chk("rst_done", 16'(cfg_done), 16'd0);
        chk("rst_cnt", echo_cnt, 16'd0);
        rst = 1'b0;
        #1;
        chk_wr("cfg01_lo", 2'b10, 8'h8A);
        step();
        chk_wr("cfg01_hi", 2'b11, 8'h02);
        chk("cfg01_done_hi", 16'(cfg_done), 16'd0);
        step();
        chk_quiet("cfg01_idle");
        chk("cfg01_done", 16'(cfg_done), 16'd1);
`ifdef DRIVER_TXQ_EN
        for (int i = 0; i < 4; i++) begin
            bus.rda = 1'b1; rx = 8'h31 + 8'(i);
            step();
            chk_rd($sformatf("q_rd%0d", i), 8'h31 + 8'(i));
            bus.rda = 1'b0;
            step();
            chk_quiet($sformatf("q_gap%0d", i));
        end
        bus.rda = 1'b1; rx = 8'h35;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet($sformatf("q_full%0d", i));
        end
        bus.rda = 1'b0; bus.tbr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_wr($sformatf("q_wr%0d", i), 2'b00, 8'h31 + 8'(i));
            step();
            chk_quiet($sformatf("q_wgap%0d", i));
        end
        chk("q_cnt", echo_cnt, 16'd4);
        step();
        chk_quiet("q_empty");
`else
        bus.rda = 1'b1; rx = 8'h41; bus.tbr = 1'b1;
        step();
        chk_rd("e41_rd", 8'h41);
        bus.rda = 1'b0;
        step();
        chk_quiet("e41_wait");
        step();
        chk_wr("e41_wr", 2'b00, 8'h41);
        step();
        chk_quiet("e41_idle");
        chk("e41_cnt", echo_cnt, 16'd1);
        bus.rda = 1'b1; rx = 8'h5A; bus.tbr = 1'b0;
        step();
        chk_rd("e5a_rd", 8'h5A);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_quiet($sformatf("e5a_hold%0d", i));
        end
        bus.tbr = 1'b1; bus.rda = 1'b0; rx = 8'h00;
        step();
        chk_wr("e5a_wr", 2'b00, 8'h5A);
        step();
        chk("e5a_cnt", echo_cnt, 16'd2);
        br_cfg = 2'b11;
        step();
        chk("cfg11_done0", 16'(cfg_done), 16'd0);
        chk_wr("cfg11_lo", 2'b10, 8'hA1);
        step();
        chk_wr("cfg11_hi", 2'b11, 8'h00);
        step();
        chk("cfg11_done", 16'(cfg_done), 16'd1);
        bus.rda = 1'b1; rx = 8'hC3; bus.tbr = 1'b0;
        step();
        chk_rd("ec3_rd", 8'hC3);
        bus.rda = 1'b0;
        step();
        br_cfg = 2'b00;
        step();
        chk_quiet("defer_wait");
        chk("defer_done", 16'(cfg_done), 16'd1);
        bus.tbr = 1'b1;
        step();
        chk_wr("defer_wr", 2'b00, 8'hC3);
        step();
        chk_quiet("defer_idle");
        chk("defer_cnt", echo_cnt, 16'd3);
        step();
        chk_wr("cfg00_lo", 2'b10, 8'h15);
        chk("cfg00_done0", 16'(cfg_done), 16'd0);
        step();
        chk_wr("cfg00_hi", 2'b11, 8'h05);
        step();
        chk("cfg00_done", 16'(cfg_done), 16'd1);
        bus.rda = 1'b1; rx = 8'h77; bus.tbr = 1'b0;
        step();
        chk_rd("e77_rd", 8'h77);
        bus.rda = 1'b0;
        step();
        rst = 1'b1; br_cfg = 2'b10;
        step();
        chk_quiet("abort");
        chk("abort_cnt", echo_cnt, 16'd0);
        chk("abort_done", 16'(cfg_done), 16'd0);
        bus.tbr = 1'b1;
        rst = 1'b0;
        #1;
        chk_wr("cfg10_lo", 2'b10, 8'h44);
        step();
        chk_wr("cfg10_hi", 2'b11, 8'h01);
        step();
        chk_quiet("no_stale0");
        step();
        chk_quiet("no_stale1");
        chk("no_stale_cnt", echo_cnt, 16'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
